// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared sizes, FSM encoding and hold-limit default for rr_arbiter8
package rr_arbiter8_pkg;
  localparam int NUM_REQ      = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 16;
  localparam int HOLD_W_DEF   = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/rr_arbiter8_pri_enc8.sv
// rtl/rr_arbiter8_pri_enc8.sv - 8-to-3 priority encoder, lowest set index wins, with any-valid flag
module pri_enc8
  import rr_arbiter8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  always_comb begin
    idx = '0;
    vld = |req;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with registered one-hot grant
// Optional forced release after MAX_HOLD cycles when ARB8_TIMEOUT_EN is defined.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
`ifdef ARB8_TIMEOUT_EN
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W   = HOLD_W_DEF
)
`endif
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [IDX_W-1:0]    gnt_idx,
  output logic                gnt_vld,
  output logic                timeout
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] req_rot;
  logic [IDX_W-1:0]   enc_idx, winner;
  logic               enc_vld, holder_req, force_rel;

  // Bit i of the rotated vector is requester (ptr + i) mod 8.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rot[i] = req[IDX_W'(i) + ptr_q];
    end
  end

  pri_enc8 u_enc (
    .req (req_rot),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  assign winner     = enc_idx + ptr_q;
  assign holder_req = req[gnt_idx_q];

`ifdef ARB8_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;

  assign force_rel = holder_req && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign timeout   = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
`ifdef ARB8_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enc_vld) begin
          state_d        = ST_GRANT;
          gnt_d          = '0;
          gnt_d[winner]  = 1'b1;
          gnt_idx_d      = winner;
`ifdef ARB8_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (!holder_req || force_rel) begin
          state_d   = ST_IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
          ptr_d     = gnt_idx_q + IDX_W'(1);
`ifdef ARB8_TIMEOUT_EN
          timeout_d = force_rel;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
`ifdef ARB8_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
`ifdef ARB8_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - table-driven and sequence checks of rr_arbiter8 through a scoreboard queue
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  always #5 clk = ~clk;

`ifdef ARB8_TIMEOUT_EN
  rr_arbiter8 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
`else
  rr_arbiter8 dut (
`endif
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } exp_t;

  typedef struct {
    logic [7:0] req;
    logic [2:0] idx;
    logic       vld;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[16];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic exp_t mk_exp(logic [2:0] idx, logic vld, logic to);
    exp_t e;
    e.gnt = vld ? (8'd1 << idx) : 8'd0;
    e.idx = vld ? idx : 3'd0;
    e.vld = vld;
    e.to  = to;
    return e;
  endfunction

  task automatic check(string tag);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_vld !== e.vld || timeout !== e.to ||
        (gnt & (gnt - 8'd1)) != 8'd0 || gnt_vld !== (|gnt)) begin
      n_bad++;
      $display("FAIL %s: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
               tag, gnt, gnt_idx, gnt_vld, timeout, e.gnt, e.idx, e.vld, e.to);
    end
  endtask

  task automatic step(logic [7:0] r, logic [2:0] idx, logic vld, logic to, string tag);
    req = r;
    sb.push_back(mk_exp(idx, vld, to));
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{8'h05, 3'd0, 1'b1};
    tbl[1]  = '{8'h05, 3'd0, 1'b1};
    tbl[2]  = '{8'h04, 3'd0, 1'b0};
    tbl[3]  = '{8'h04, 3'd2, 1'b1};
    tbl[4]  = '{8'h00, 3'd0, 1'b0};
    tbl[5]  = '{8'h40, 3'd6, 1'b1};
    tbl[6]  = '{8'h00, 3'd0, 1'b0};
    tbl[7]  = '{8'h81, 3'd7, 1'b1};
    tbl[8]  = '{8'h01, 3'd0, 1'b0};
    tbl[9]  = '{8'h01, 3'd0, 1'b1};
    tbl[10] = '{8'h00, 3'd0, 1'b0};
    tbl[11] = '{8'h03, 3'd1, 1'b1};
    tbl[12] = '{8'h01, 3'd0, 1'b0};
    tbl[13] = '{8'h03, 3'd0, 1'b1};
    tbl[14] = '{8'h02, 3'd0, 1'b0};
    tbl[15] = '{8'h00, 3'd0, 1'b0};

    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (2) @(negedge clk);
    sb.push_back(mk_exp(3'd0, 1'b0, 1'b0));
    check("reset_hold");
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].req, tbl[i].idx, tbl[i].vld, 1'b0, $sformatf("table[%0d]", i));
    end

    reset_pulse();
    for (int k = 0; k <= 8; k++) begin
      logic [2:0] w;
      w = 3'(k % 8);
      step(8'hFF, w, 1'b1, 1'b0, $sformatf("fair_grant[%0d]", k));
      step(8'hFF, w, 1'b1, 1'b0, $sformatf("fair_hold[%0d]", k));
      step(8'hFF & ~(8'd1 << w), 3'd0, 1'b0, 1'b0, $sformatf("fair_release[%0d]", k));
    end

`ifdef ARB8_TIMEOUT_EN
    reset_pulse();
    for (int c = 0; c < 4; c++) step(8'h03, 3'd0, 1'b1, 1'b0, $sformatf("to_hold0[%0d]", c));
    step(8'h03, 3'd0, 1'b0, 1'b1, "to_pulse0");
    for (int c = 0; c < 4; c++) step(8'h03, 3'd1, 1'b1, 1'b0, $sformatf("to_hold1[%0d]", c));
    step(8'h03, 3'd0, 1'b0, 1'b1, "to_pulse1");
    step(8'h03, 3'd0, 1'b1, 1'b0, "to_regrant0");
    step(8'h00, 3'd0, 1'b0, 1'b0, "to_release");
`else
    step(8'h08, 3'd3, 1'b1, 1'b0, "nopre_grant");
    for (int c = 0; c < 50; c++) begin
      step(8'($urandom) | 8'h08, 3'd3, 1'b1, 1'b0, $sformatf("nopre[%0d]", c));
    end
    step(8'h00, 3'd0, 1'b0, 1'b0, "nopre_release");
`endif

    step(8'h01, 3'd0, 1'b1, 1'b0, "pre_async_grant");
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk_exp(3'd0, 1'b0, 1'b0));
    check("async_reset_mid_grant");
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h81, 3'd0, 1'b1, 1'b0, "ptr_after_reset");
    step(8'h00, 3'd0, 1'b0, 1'b0, "final_release");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
